// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-meter sequencer.
//   - state_t       : sequencer states for both frame formats
//   - CR, LF        : line-ending bytes of the ASCII frame
//   - GATE_CYCLES_DEF : default counting window length in clk_in cycles
//   - nib2hex()     : 4-bit value to uppercase ASCII hex character
package freq_meas_pkg;

  localparam int unsigned GATE_CYCLES_DEF = 12_500_000;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HDR,
    ST_CNT,
    ST_SUM,
    ST_HI,
    ST_LO,
    ST_CR,
    ST_LF
  } state_t;

  // '0'-'9' -> 8'h30-8'h39, 'A'-'F' -> 8'h41-8'h46
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Byte stream from the sequencer to the UART transmitter.
//   tx_data  : byte to send
//   tx_valid : tx_data is valid; held with tx_data until accepted
//   tx_ready : receiver accepts tx_data at this clock edge
// master = sequencer side, slave = UART TX side.
interface freq_meas_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/freq_gate_timer.sv
// Free-running counting-window timer.
//   clk_in   : system clock
//   rst_in   : synchronous active-high reset
//   gate_out : registered one-cycle pulse, high in the cycle where the
//              timer holds GATE_CYCLES-1; period is GATE_CYCLES cycles
module freq_gate_timer
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic gate_out
);

  localparam logic [23:0] LAST = 24'(GATE_CYCLES - 1);
  localparam logic [23:0] PRE  = 24'(GATE_CYCLES - 2);

  logic [23:0] timer;

  // gate_out is registered, so it is raised from the value one below the
  // terminal count to line up with timer == GATE_CYCLES-1.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      timer    <= '0;
      gate_out <= 1'b0;
    end else begin
      timer    <= (timer == LAST) ? 24'd0 : timer + 24'd1;
      gate_out <= (timer == PRE);
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Frequency-meter sequencer: closes each counting window on the edge
// counter, captures the finished count and sends it as a framed byte
// sequence to the UART transmitter.
//   clk_in      : system clock
//   rst_in      : synchronous active-high reset (aborts a frame in flight)
//   count_in    : counter data_out
//   gate_out    : one-cycle window-close pulse to the counter's tim025
//   tx          : byte stream to UART TX (freq_meas_ctrl_if.master)
//   busy_out    : a frame is pending or being sent
//   overrun_out : sticky; a window closed while a frame was still in flight
// Build option FREQ_MEAS_ASCII_EN: frame is two uppercase hex characters
// followed by CR LF instead of the binary HEADER/count/checksum frame.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              count_in,
  output logic                    gate_out,
  freq_meas_ctrl_if.master        tx,
  output logic                    busy_out,
  output logic                    overrun_out
);

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic [7:0] tx_data_c;
  logic       tx_valid_c;

  freq_gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .gate_out (gate_out)
  );

  always_comb begin
    state_nx   = state;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    case (state)
      ST_IDLE:    if (gate_out) state_nx = ST_CAPTURE;
`ifdef FREQ_MEAS_ASCII_EN
      ST_CAPTURE: state_nx = ST_HI;
      ST_HI: begin
        tx_valid_c = 1'b1;
        tx_data_c  = nib2hex(cnt[7:4]);
        if (tx.tx_ready) state_nx = ST_LO;
      end
      ST_LO: begin
        tx_valid_c = 1'b1;
        tx_data_c  = nib2hex(cnt[3:0]);
        if (tx.tx_ready) state_nx = ST_CR;
      end
      ST_CR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = CR;
        if (tx.tx_ready) state_nx = ST_LF;
      end
      ST_LF: begin
        tx_valid_c = 1'b1;
        tx_data_c  = LF;
        if (tx.tx_ready) state_nx = ST_IDLE;
      end
`else
      ST_CAPTURE: state_nx = ST_HDR;
      ST_HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = HEADER;
        if (tx.tx_ready) state_nx = ST_CNT;
      end
      ST_CNT: begin
        tx_valid_c = 1'b1;
        tx_data_c  = cnt;
        if (tx.tx_ready) state_nx = ST_SUM;
      end
      ST_SUM: begin
        tx_valid_c = 1'b1;
        tx_data_c  = HEADER + cnt;
        if (tx.tx_ready) state_nx = ST_IDLE;
      end
`endif
      default:    state_nx = ST_IDLE;
    endcase
  end

  // The counter may still increment on the edge that ends the gate cycle,
  // so the count is taken one edge later, at the end of CAPTURE.
  // A window closing outside IDLE (even on the final handshake) is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      cnt         <= 8'h00;
      overrun_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_CAPTURE) cnt <= count_in;
      if (gate_out && (state != ST_IDLE)) overrun_out <= 1'b1;
    end
  end

  assign tx.tx_valid = tx_valid_c;
  assign tx.tx_data  = tx_data_c;
  assign busy_out    = (state != ST_IDLE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
module tb_freq_meas_ctrl;

  localparam int GC = 20;
`ifdef FREQ_MEAS_ASCII_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] count_in;
  logic       gate_out;
  logic       busy_out;
  logic       overrun_out;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  freq_meas_ctrl_if tx_if ();

  freq_meas_ctrl #(.GATE_CYCLES(GC), .HEADER(8'hA5)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .count_in    (count_in),
    .gate_out    (gate_out),
    .tx          (tx_if.master),
    .busy_out    (busy_out),
    .overrun_out (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected frame byte idx for a captured count c.
  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] c, input int idx);
`ifdef FREQ_MEAS_ASCII_EN
    case (idx)
      0:       return hexc(c[7:4]);
      1:       return hexc(c[3:0]);
      2:       return 8'h0D;
      default: return 8'h0A;
    endcase
`else
    case (idx)
      0:       return 8'hA5;
      1:       return c;
      default: return 8'(9'h0A5 + {1'b0, c});
    endcase
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // Advance until gate_out is seen; reports its cycle index and whether
  // tx_valid appeared while waiting.
  task automatic wait_gate(output int at, output int stray);
    int n = 0;
    stray = 0;
    while (!gate_out && n < 100) begin
      if (tx_if.tx_valid) stray++;
      tick();
      n++;
    end
    at = gate_out ? cyc : -1;
  endtask

  task automatic get_byte(output logic [7:0] b);
    int n = 0;
    while (!(tx_if.tx_valid && tx_if.tx_ready) && n < 60) begin
      tick();
      n++;
    end
    if (tx_if.tx_valid && tx_if.tx_ready) b = tx_if.tx_data;
    else b = 8'hxx;
    tick();
  endtask

  task automatic get_frame(input string tag, input logic [7:0] c, input int first);
    logic [7:0] b;
    for (int i = first; i < FL; i++) begin
      get_byte(b);
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, b}, {24'h0, exp_byte(c, i)});
    end
  endtask

  initial begin
    int at, stray;
    rst_in = 1'b1;
    count_in = 8'h00;
    tx_if.tx_ready = 1'b1;
    tick();
    tick();
    // reset state
    chk("rst_gate",    {31'h0, gate_out},       32'h0);
    chk("rst_valid",   {31'h0, tx_if.tx_valid}, 32'h0);
    chk("rst_data",    {24'h0, tx_if.tx_data},  32'h0);
    chk("rst_busy",    {31'h0, busy_out},       32'h0);
    chk("rst_overrun", {31'h0, overrun_out},    32'h0);
    rst_in = 1'b0;
    cyc = 0;

    // first window, count 00
    wait_gate(at, stray);
    chk("gate1_cycle", at, GC - 1);
    chk("gate1_stray", stray, 0);
    tick();
    chk("gate1_width",   {31'h0, gate_out},       32'h0);
    chk("capture_valid", {31'h0, tx_if.tx_valid}, 32'h0);
    chk("capture_busy",  {31'h0, busy_out},       32'h1);
    get_frame("f00", 8'h00, 0);
    chk("f00_idle", {31'h0, busy_out}, 32'h0);

    // late increment during the edge ending the gate cycle is captured
    count_in = 8'h10;
    wait_gate(at, stray);
    chk("gate2_cycle", at, 2 * GC - 1);
    tick();
    count_in = 8'h12;
    tick();
    count_in = 8'h00;
    get_frame("f12", 8'h12, 0);

    // checksum wrap
    count_in = 8'hFA;
    wait_gate(at, stray);
    chk("gate3_cycle", at, 3 * GC - 1);
    get_frame("fFA", 8'hFA, 0);

    // backpressure on the second byte
    count_in = 8'h3C;
    wait_gate(at, stray);
    chk("gate4_cycle", at, 4 * GC - 1);
    tick();
    tick();
    chk("bp_first", {24'h0, tx_if.tx_data}, {24'h0, exp_byte(8'h3C, 0)});
    tick();
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), {31'h0, tx_if.tx_valid}, 32'h1);
      chk($sformatf("bp_data%0d", i),  {24'h0, tx_if.tx_data},  {24'h0, exp_byte(8'h3C, 1)});
      chk($sformatf("bp_busy%0d", i),  {31'h0, busy_out},       32'h1);
      tick();
    end
    tx_if.tx_ready = 1'b1;
    get_frame("f3C", 8'h3C, 1);
    chk("f3C_idle", {31'h0, busy_out}, 32'h0);

    // overrun: ready held low across the next window close
    count_in = 8'h55;
    wait_gate(at, stray);
    chk("gate5_cycle", at, 5 * GC - 1);
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("ovr_set",   {31'h0, overrun_out},    32'h1);
    chk("ovr_valid", {31'h0, tx_if.tx_valid}, 32'h1);
    chk("ovr_data",  {24'h0, tx_if.tx_data},  {24'h0, exp_byte(8'h55, 0)});
    tx_if.tx_ready = 1'b1;
    get_frame("f55", 8'h55, 0);
    chk("ovr_idle",   {31'h0, busy_out},    32'h0);
    chk("ovr_sticky", {31'h0, overrun_out}, 32'h1);
    count_in = 8'h07;
    wait_gate(at, stray);
    chk("gate7_cycle", at, 7 * GC - 1);
    chk("ovr_dropped", stray, 0);
    get_frame("f07", 8'h07, 0);

    // reset in the middle of a frame
    count_in = 8'h66;
    wait_gate(at, stray);
    chk("gate8_cycle", at, 8 * GC - 1);
    tick();
    tick();
    tick();
    chk("midrst_pre_valid", {31'h0, tx_if.tx_valid}, 32'h1);
    rst_in = 1'b1;
    tick();
    chk("midrst_valid",   {31'h0, tx_if.tx_valid}, 32'h0);
    chk("midrst_busy",    {31'h0, busy_out},       32'h0);
    chk("midrst_overrun", {31'h0, overrun_out},    32'h0);
    chk("midrst_data",    {24'h0, tx_if.tx_data},  32'h0);
    rst_in = 1'b0;
    cyc = 0;
    wait_gate(at, stray);
    chk("midrst_gate_cycle", at, GC - 1);
    chk("midrst_stray", stray, 0);
    get_frame("f66", 8'h66, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer for the edge-counting frequency meter.
- Generates the periodic gate pulse that closes each counting window on the counter, captures the finished 8-bit count, and streams it as a framed byte sequence to the UART transmitter over a valid/ready handshake.
- Sits between the counter (drives its tim025 input, reads its data_out) and the UART TX block.

Parameters:
- GATE_CYCLES, 12_500_000, clk_in cycles per counting window (0.25 s at 50 MHz); legal range 8 to 2^24-1.
- HEADER, 8'hA5, first byte of every binary frame.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- count_in  input  8  count value from the counter's data_out.
- gate_out  output  1  one-cycle window-close pulse; drives the counter's tim025.
- tx_data  output  8  byte to UART TX.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX accepts tx_data.
- busy_out  output  1  high while a frame is pending or being sent (state != IDLE).
- overrun_out  output  1  sticky; a window closed while the previous frame was still in flight.

Behaviour:
- Reset values (rst_in sampled high at a clock edge):
  - timer=0, gate_out=0, tx_valid=0, tx_data=0, busy_out=0, overrun_out=0.
  - state=IDLE, captured count=0.
  - Reset mid-frame aborts it; tx_valid is low the cycle after reset.
- Gate timer:
  - 24-bit free-running counter 0..GATE_CYCLES-1, wraps to 0.
  - gate_out is registered and high for exactly the cycle in which timer==GATE_CYCLES-1; period is exactly GATE_CYCLES cycles.
  - The timer never stalls for TX backpressure.
- Capture timing:
  - The counter may still increment at the edge that ends the gate cycle, then clears one cycle later.
  - Therefore count_in is sampled at the edge ending the cycle after gate_out (state CAPTURE).
- FSM, binary frame:
  - IDLE: on gate_out -> CAPTURE.
  - CAPTURE: latch cnt=count_in -> HDR.
  - HDR: tx_data=HEADER, tx_valid=1 -> CNT on handshake.
  - CNT: tx_data=cnt -> SUM on handshake.
  - SUM: tx_data=(HEADER+cnt) mod 256 -> IDLE on handshake.
- Handshake rules:
  - A byte transfers at an edge where tx_valid and tx_ready are both high.
  - tx_valid and tx_data stay stable until transfer.
  - tx_valid is low in IDLE and CAPTURE.
  - Back-to-back bytes are allowed: the next byte is presented the cycle after transfer.
- Overrun:
  - gate_out high while state != IDLE (including the cycle of the final SUM handshake) drops that window; the in-flight frame completes unchanged.
  - overrun_out is set and stays high until reset.
- Minimum frame time with tx_ready tied high: 1 CAPTURE cycle + 3 byte cycles. GATE_CYCLES >= 8 guarantees no overrun when tx_ready is tied high.

Optional Feature:
- Macro: FREQ_MEAS_ASCII_EN.
- Defined:
  - Frame is ASCII hex, 4 bytes: hex char of cnt[7:4], hex char of cnt[3:0], 8'h0D, 8'h0A.
  - Hex chars are uppercase ('0'-'9' = 8'h30-8'h39, 'A'-'F' = 8'h41-8'h46).
  - States HI, LO, CR, LF replace HDR, CNT, SUM. HEADER is unused.
- Undefined: binary 3-byte frame as above.
- All other behaviour (gate, capture, overrun, reset) is identical in both builds.

Decomposition:
- Shared package freq_meas_pkg:
  - State encodings (IDLE, CAPTURE, HDR, CNT, SUM, HI, LO, CR, LF).
  - Constants CR=8'h0D, LF=8'h0A.
  - Default GATE_CYCLES.
  - Nibble-to-ASCII function.
- Natural sub-module: freq_gate_timer (timer plus registered gate_out, parameter GATE_CYCLES), instantiated once.
- FSM and frame formatting stay in the top module.

Test Plan (GATE_CYCLES=20 unless noted):
- Reset release, tx_ready=1, count_in=8'h00 -> first gate_out exactly 20 cycles after reset deasserts, then pulses every 20 cycles, each 1 cycle wide; frame A5,00,A5.
- count_in stepped 8'h10 -> 8'h12 on the edge ending the gate_out cycle, held through CAPTURE -> frame A5,12,B7 (the late increment is captured).
- count_in=8'hFA -> SUM byte 8'h9F (mod-256 wrap).
- tx_ready low for 5 cycles during CNT -> tx_valid stays high with tx_data=cnt unchanged; the byte transfers once on the first ready cycle; busy_out stays high throughout.
- tx_ready held low for 25 cycles -> second gate_out arrives while HDR is pending: overrun_out=1 and sticky; only one frame sent; the next window after IDLE is captured normally.
- rst_in asserted during CNT -> next cycle tx_valid=0, busy_out=0, overrun_out=0, timer restarts; the next gate_out comes 20 cycles after reset deasserts.
- FREQ_MEAS_ASCII_EN defined, count_in=8'h3C -> bytes 33,43,0D,0A.
